// File: rtl/table_scan_seq.sv
// Sequential key search over a DEPTH-entry table of {key, f0, f1}, one entry per cycle,
// with valid/ready handshakes on request and response; first or last match selectable.
module table_scan_seq #(
    parameter int  DATA_W     = 8,
    parameter int  DEPTH      = 9,
    parameter bit  MATCH_LAST = 1'b0,
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_key,
    input  logic [DATA_W-1:0] wr_f0,
    input  logic [DATA_W-1:0] wr_f1,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_key,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [IDX_W-1:0]  rsp_idx,
    output logic [DATA_W-1:0] rsp_f0,
    output logic [DATA_W-1:0] rsp_f1,
    output logic              busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_RESP} state_e;

    logic [DATA_W-1:0] tab_key_q [DEPTH];
    logic [DATA_W-1:0] tab_f0_q  [DEPTH];
    logic [DATA_W-1:0] tab_f1_q  [DEPTH];
    logic [DEPTH-1:0]  tab_vld_q;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] skey_q, skey_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              hit_q, hit_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] f0_q, f0_d;
    logic [DATA_W-1:0] f1_q, f1_d;
    logic              match;

    // NOTE: table contents are reset too, so a post-reset table reads as all-zero, not X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_key_q[i] <= '0;
                tab_f0_q[i]  <= '0;
                tab_f1_q[i]  <= '0;
            end
            tab_vld_q <= '0;
        end else begin
            if (clr) tab_vld_q <= '0;
            // The per-entry write comes after the clear so it wins for wr_addr;
            // addresses >= DEPTH match no entry and are dropped.
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && wr_addr == IDX_W'(i)) begin
                    tab_key_q[i] <= wr_key;
                    tab_f0_q[i]  <= wr_f0;
                    tab_f1_q[i]  <= wr_f1;
                    tab_vld_q[i] <= 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            skey_q  <= '0;
            ptr_q   <= '0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            f0_q    <= '0;
            f1_q    <= '0;
        end else begin
            state_q <= state_d;
            skey_q  <= skey_d;
            ptr_q   <= ptr_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            f0_q    <= f0_d;
            f1_q    <= f1_d;
        end
    end

    assign match = tab_vld_q[ptr_q] && (tab_key_q[ptr_q] == skey_q);

    // NOTE: every _d gets its hold value first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state_q;
        skey_d  = skey_q;
        ptr_d   = ptr_q;
        hit_d   = hit_q;
        idx_d   = idx_q;
        f0_d    = f0_q;
        f1_d    = f1_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    skey_d  = req_key;
                    ptr_d   = '0;
                    hit_d   = 1'b0;
                    idx_d   = '0;
                    f0_d    = '0;
                    f1_d    = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (match) begin
                    hit_d = 1'b1;
                    idx_d = ptr_q;
                    f0_d  = tab_f0_q[ptr_q];
                    f1_d  = tab_f1_q[ptr_q];
                end
                if (match && !MATCH_LAST) begin
                    state_d = ST_RESP;
                end else if (ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_RESP;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        busy      = (state_q != ST_IDLE);
        rsp_hit   = hit_q;
        rsp_idx   = idx_q;
        rsp_f0    = f0_q;
        rsp_f1    = f1_q;
    end

endmodule

// File: tb/tb_table_scan_seq.sv
// Bench for table_scan_seq: one first-match and one last-match instance share the write port;
// fixed vectors, hand-written corner sequences, then random searches against a table model.
module tb_table_scan_seq;

    localparam int DEPTH = 9;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_key, wr_f0, wr_f1;
    logic       clr;
    logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready, rsp_hit, busy;
    logic [7:0] req_key [2];
    logic [3:0] rsp_idx [2];
    logic [7:0] rsp_f0  [2];
    logic [7:0] rsp_f1  [2];

    always #5 clk = ~clk;

    table_scan_seq #(.DATA_W(8), .DEPTH(DEPTH), .MATCH_LAST(1'b0)) u_first (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_key(wr_key),
        .wr_f0(wr_f0), .wr_f1(wr_f1), .clr(clr), .req_valid(req_valid[0]),
        .req_ready(req_ready[0]), .req_key(req_key[0]), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]), .rsp_hit(rsp_hit[0]), .rsp_idx(rsp_idx[0]),
        .rsp_f0(rsp_f0[0]), .rsp_f1(rsp_f1[0]), .busy(busy[0])
    );

    table_scan_seq #(.DATA_W(8), .DEPTH(DEPTH), .MATCH_LAST(1'b1)) u_last (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_key(wr_key),
        .wr_f0(wr_f0), .wr_f1(wr_f1), .clr(clr), .req_valid(req_valid[1]),
        .req_ready(req_ready[1]), .req_key(req_key[1]), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]), .rsp_hit(rsp_hit[1]), .rsp_idx(rsp_idx[1]),
        .rsp_f0(rsp_f0[1]), .rsp_f1(rsp_f1[1]), .busy(busy[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference table: what a correct block would hold after each edge.
    logic [7:0] m_key [DEPTH];
    logic [7:0] m_f0  [DEPTH];
    logic [7:0] m_f1  [DEPTH];
    bit         m_vld [DEPTH];

    typedef struct {
        int         dut;
        logic [7:0] key;
        int         lat;
        bit         hit;
        int         idx;
        logic [7:0] f0;
        logic [7:0] f1;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_key[i] = '0; m_f0[i] = '0; m_f1[i] = '0; m_vld[i] = 1'b0;
        end
    endfunction

    // d=0 stops at the first hit; d=1 walks the whole table and keeps the last hit.
    function automatic void model_search(input int d, input logic [7:0] key, output int lat,
                                         output bit hit, output int idx,
                                         output logic [7:0] f0, output logic [7:0] f1);
        lat = DEPTH; hit = 1'b0; idx = 0; f0 = '0; f1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_vld[i] && m_key[i] == key) begin
                hit = 1'b1; idx = i; f0 = m_f0[i]; f1 = m_f1[i];
                if (d == 0) begin
                    lat = i + 1;
                    break;
                end
            end
        end
    endfunction

    // One clock with the write port and clear driven; model follows at the edge.
    task automatic wr_cycle(input bit we, input logic [3:0] addr, input logic [7:0] key,
                            input logic [7:0] f0, input logic [7:0] f1, input bit c);
        wr_en = we; wr_addr = addr; wr_key = key; wr_f0 = f0; wr_f1 = f1; clr = c;
        @(posedge clk); #1;
        wr_en = 1'b0; clr = 1'b0;
        if (c) for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        if (we && int'(addr) < DEPTH) begin
            m_key[addr] = key; m_f0[addr] = f0; m_f1[addr] = f1; m_vld[addr] = 1'b1;
        end
    endtask

    task automatic issue(input int d, input logic [7:0] key, input string tag);
        check({tag, ".rdy"}, req_ready[d], 1);
        req_valid[d] = 1'b1; req_key[d] = key;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_rsp(input int d, inout int n);
        while (!rsp_valid[d] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_rsp(input int d, input int n, input int lat, input bit hit,
                             input int idx, input logic [7:0] f0, input logic [7:0] f1,
                             input string tag);
        check({tag, ".lat"}, n, lat);
        check({tag, ".hit"}, rsp_hit[d], hit);
        check({tag, ".idx"}, rsp_idx[d], idx);
        check({tag, ".f0"},  rsp_f0[d], f0);
        check({tag, ".f1"},  rsp_f1[d], f1);
    endtask

    task automatic finish_rsp(input int d, input string tag);
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        check({tag, ".vdrop"}, rsp_valid[d], 0);
        check({tag, ".rrise"}, req_ready[d], 1);
        check({tag, ".idle"},  busy[d], 0);
    endtask

    task automatic run_search(input int d, input logic [7:0] key, input int lat, input bit hit,
                              input int idx, input logic [7:0] f0, input logic [7:0] f1,
                              input string tag);
        int n;
        issue(d, key, tag);
        n = 0;
        wait_rsp(d, n);
        check_rsp(d, n, lat, hit, idx, f0, f1, tag);
        finish_rsp(d, tag);
    endtask

    initial begin
        int         n, d, el, ei;
        bit         eh;
        logic [7:0] key, ef0, ef1;

        vecs[0] = '{0, 8'd14, 5, 1'b1, 4, 8'd4,  8'd8};
        vecs[1] = '{0, 8'd99, 9, 1'b0, 0, 8'd0,  8'd0};
        vecs[2] = '{0, 8'd10, 1, 1'b1, 0, 8'd0,  8'd0};
        vecs[3] = '{0, 8'd18, 9, 1'b1, 8, 8'd8,  8'd16};
        vecs[4] = '{1, 8'd14, 9, 1'b1, 4, 8'd4,  8'd8};
        vecs[5] = '{1, 8'd99, 9, 1'b0, 0, 8'd0,  8'd0};
        vecs[6] = '{0, 8'd7,  3, 1'b1, 2, 8'hA2, 8'hB2};
        vecs[7] = '{1, 8'd7,  9, 1'b1, 6, 8'hA6, 8'hB6};
        vecs[8] = '{0, 8'd16, 9, 1'b0, 0, 8'd0,  8'd0};

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_key = '0; wr_f0 = '0; wr_f1 = '0;
        clr = 1'b0; req_valid = '0; rsp_ready = '0; req_key[0] = '0; req_key[1] = '0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst.rdy",  req_ready[i], 1);
            check("rst.vld",  rsp_valid[i], 0);
            check("rst.busy", busy[i], 0);
            check("rst.hit",  rsp_hit[i], 0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++)
            wr_cycle(1'b1, 4'(i), 8'(10 + i), 8'(i), 8'(2 * i), 1'b0);
        wr_cycle(1'b1, 4'd12, 8'd99, 8'h5A, 8'h5B, 1'b0);
        for (int i = 0; i < 6; i++)
            run_search(vecs[i].dut, vecs[i].key, vecs[i].lat, vecs[i].hit, vecs[i].idx,
                       vecs[i].f0, vecs[i].f1, $sformatf("vec%0d", i));

        wr_cycle(1'b1, 4'd2, 8'd7, 8'hA2, 8'hB2, 1'b0);
        wr_cycle(1'b1, 4'd6, 8'd7, 8'hA6, 8'hB6, 1'b0);
        for (int i = 6; i < 9; i++)
            run_search(vecs[i].dut, vecs[i].key, vecs[i].lat, vecs[i].hit, vecs[i].idx,
                       vecs[i].f0, vecs[i].f1, $sformatf("vec%0d", i));

        // Response held off for 5 cycles while its own entry is rewritten.
        issue(0, 8'd14, "hold");
        n = 0;
        wait_rsp(0, n);
        check("hold.lat", n, 5);
        for (int j = 0; j < 5; j++) begin
            if (j == 2) begin
                wr_en = 1'b1; wr_addr = 4'd4; wr_key = 8'd14; wr_f0 = 8'h55; wr_f1 = 8'h66;
            end
            @(posedge clk); #1;
            wr_en = 1'b0;
            check("hold.vld", rsp_valid[0], 1);
            check("hold.rdy", req_ready[0], 0);
            check("hold.idx", rsp_idx[0], 4);
            check("hold.f0",  rsp_f0[0], 8'd4);
            check("hold.f1",  rsp_f1[0], 8'd8);
        end
        m_f0[4] = 8'h55; m_f1[4] = 8'h66;
        finish_rsp(0, "hold");
        run_search(0, 8'd14, 5, 1'b1, 4, 8'h55, 8'h66, "rewr");

        // Clear during scan cycle 2 hides entry 5 from the rest of the scan.
        wr_cycle(1'b1, 4'd5, 8'h77, 8'h35, 8'h53, 1'b0);
        issue(0, 8'h77, "clr");
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        n = 2;
        wait_rsp(0, n);
        check_rsp(0, n, 9, 1'b0, 0, 8'h0, 8'h0, "clr");
        finish_rsp(0, "clr");

        // Same, but entry 5 is written on the clear edge, so it survives.
        issue(0, 8'h77, "clrwr");
        @(posedge clk); #1;
        clr = 1'b1; wr_en = 1'b1; wr_addr = 4'd5; wr_key = 8'h77; wr_f0 = 8'h36; wr_f1 = 8'h63;
        @(posedge clk); #1;
        clr = 1'b0; wr_en = 1'b0;
        m_key[5] = 8'h77; m_f0[5] = 8'h36; m_f1[5] = 8'h63; m_vld[5] = 1'b1;
        n = 2;
        wait_rsp(0, n);
        check_rsp(0, n, 6, 1'b1, 5, 8'h36, 8'h63, "clrwr");
        finish_rsp(0, "clrwr");

        for (int it = 0; it < 30; it++) begin
            n = $urandom_range(0, 3);
            for (int w = 0; w < n; w++)
                wr_cycle(1'b1, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 5)),
                         8'($urandom), 8'($urandom), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 7) == 0) wr_cycle(1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 1'b1);
            d   = $urandom_range(0, 1);
            key = 8'($urandom_range(0, 5));
            model_search(d, key, el, eh, ei, ef0, ef1);
            run_search(d, key, el, eh, ei, ef0, ef1, $sformatf("rnd%0d", it));
        end

        // Asynchronous reset in the middle of a scan.
        wr_cycle(1'b1, 4'd8, 8'd3, 8'h01, 8'h02, 1'b0);
        issue(0, 8'd3, "arst");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("arst.rdy",  req_ready[i], 1);
            check("arst.vld",  rsp_valid[i], 0);
            check("arst.busy", busy[i], 0);
            check("arst.hit",  rsp_hit[i], 0);
            check("arst.idx",  rsp_idx[i], 0);
            check("arst.f0",   rsp_f0[i], 0);
            check("arst.f1",   rsp_f1[i], 0);
        end
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst.norsp", rsp_valid[0], 0);
        run_search(0, 8'd0, 9, 1'b0, 0, 8'h0, 8'h0, "post0");
        run_search(1, 8'd3, 9, 1'b0, 0, 8'h0, 8'h0, "post1");
        wr_cycle(1'b1, 4'd3, 8'd0, 8'h11, 8'h22, 1'b0);
        run_search(0, 8'd0, 4, 1'b1, 3, 8'h11, 8'h22, "key0a");
        run_search(1, 8'd0, 9, 1'b1, 3, 8'h11, 8'h22, "key0b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
